big_subtractor: RTL and testbench

BIG_SUBTRACTOR -- requirements
Module: big_subtractor

---
 rtl/big_subtractor.sv | 115 +++++++++++
 tb/tb_big_subtractor.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/big_subtractor.sv
// -----------------------------------------------------------------------------
// big_subtractor
//
// Two-stage pipelined 17-bit minus 8-bit unsigned subtractor.
//   Stage 1 subtracts the subtrahend from the low byte of the minuend and
//   captures the resulting low-byte borrow.
//   Stage 2 propagates that borrow into the upper 9 bits. It then publishes
//   the difference, the final borrow and the bookkeeping outputs.
// One operand pair is accepted every cycle, with no backpressure. A result
// appears one edge after the edge that accepted its operands.
//
// Ports
//   clock        : single clock; all state changes on its rising edge
//   reset        : synchronous, active-high; clears all state
//   in_valid     : in1/in2 hold an operand pair to accept this cycle
//   in1[16:0]    : minuend, unsigned
//   in2[7:0]     : subtrahend, unsigned (zero-extended to 17 bits)
//   clear_flag   : clears the sticky underflow flag
//   out_valid    : one-cycle pulse per result
//   out[16:0]    : (in1 - in2) mod 2^17
//   borrow       : in1 < in2 for the result on out
//   underflow    : sticky record that some result had borrow = 1
//   result_count : number of results delivered, modulo 256
// -----------------------------------------------------------------------------
module big_subtractor (
    input  logic        clock,
    input  logic        reset,
    input  logic        in_valid,
    input  logic [16:0] in1,
    input  logic [7:0]  in2,
    input  logic        clear_flag,
    output logic        out_valid,
    output logic [16:0] out,
    output logic        borrow,
    output logic        underflow,
    output logic [7:0]  result_count
);

    localparam int LO_W = 8;
    localparam int HI_W = 9;

    // Stage-1 pipeline registers
    logic            s1_valid;
    logic [LO_W-1:0] s1_d_lo;
    logic            s1_b8;
    logic [HI_W-1:0] s1_hi;

    // Combinational helpers
    logic [LO_W:0]   lo_diff;      // 9-bit low-byte difference; MSB is the borrow
    logic [HI_W-1:0] hi_dec;       // upper bits after absorbing the low-byte borrow
    logic            borrow_next;  // borrow for the whole 17-bit result

    // NOTE: every signal written in always_comb gets a default at the top, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        lo_diff     = '0;
        hi_dec      = '0;
        borrow_next = 1'b0;

        // Extending both operands by one zero bit makes the MSB of the
        // difference equal to (in1[7:0] < in2). No separate comparator is needed.
        lo_diff     = {1'b0, in1[LO_W-1:0]} - {1'b0, in2};

        hi_dec      = s1_hi - {{(HI_W-1){1'b0}}, s1_b8};
        // The full result goes negative only when the upper bits are all zero
        // and the low byte still has to borrow.
        borrow_next = (s1_hi == '0) && s1_b8;
    end

    // Stage 1: low-byte subtraction
    // NOTE: sequential state is updated with non-blocking assignments (<=). Every register then samples pre-edge values, independent of block ordering.
    // NOTE: the datapath registers are reset as well as the valid bit. An aborted operand then leaves no trace in the pipeline.
    always_ff @(posedge clock) begin
        if (reset) begin
            s1_valid <= 1'b0;
            s1_d_lo  <= '0;
            s1_b8    <= 1'b0;
            s1_hi    <= '0;
        end else begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_d_lo <= lo_diff[LO_W-1:0];
                s1_b8   <= lo_diff[LO_W];
                s1_hi   <= in1[16:LO_W];
            end
        end
    end

    // Stage 2: borrow propagation and result publication
    always_ff @(posedge clock) begin
        if (reset) begin
            out_valid    <= 1'b0;
            out          <= '0;
            borrow       <= 1'b0;
            underflow    <= 1'b0;
            result_count <= '0;
        end else begin
            out_valid <= s1_valid;

            // out and borrow hold their values between results.
            if (s1_valid) begin
                out          <= {hi_dec, s1_d_lo};
                borrow       <= borrow_next;
                result_count <= result_count + 8'd1;
            end

            // Setting the flag takes priority over a simultaneous clear.
            if (s1_valid && borrow_next) begin
                underflow <= 1'b1;
            end else if (clear_flag) begin
                underflow <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_big_subtractor.sv
// -----------------------------------------------------------------------------
// tb_big_subtractor
//
// Self-checking bench for big_subtractor.
// - A behavioural model keeps a time-stamped queue of pending differences,
//   computed with plain 17-bit arithmetic. A compare process checks every
//   output on every falling edge once reset has been seen.
// - Directed vectors check hand-computed literal results.
// -----------------------------------------------------------------------------
module tb_big_subtractor;

    logic        clock;
    logic        reset;
    logic        in_valid;
    logic [16:0] in1;
    logic [7:0]  in2;
    logic        clear_flag;
    logic        out_valid;
    logic [16:0] out;
    logic        borrow;
    logic        underflow;
    logic [7:0]  result_count;

    int tests;
    int fails;

    big_subtractor dut (
        .clock        (clock),
        .reset        (reset),
        .in_valid     (in_valid),
        .in1          (in1),
        .in2          (in2),
        .clear_flag   (clear_flag),
        .out_valid    (out_valid),
        .out          (out),
        .borrow       (borrow),
        .underflow    (underflow),
        .result_count (result_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct {
        int          due;
        logic [16:0] diff;
        logic        brw;
    } pending_t;

    pending_t    pend[$];
    int          cyc;
    bit          model_live;
    logic        exp_valid;
    logic [16:0] exp_out;
    logic        exp_borrow;
    logic        exp_uf;
    int          exp_cnt;

    initial begin
        cyc        = 0;
        model_live = 1'b0;
    end

    always @(posedge clock) begin
        pending_t item;
        bit       popped;
        cyc++;
        if (reset) begin
            pend.delete();
            exp_valid  = 1'b0;
            exp_out    = '0;
            exp_borrow = 1'b0;
            exp_uf     = 1'b0;
            exp_cnt    = 0;
            model_live = 1'b1;
        end else if (model_live) begin
            popped    = 1'b0;
            exp_valid = 1'b0;
            if (pend.size() > 0 && pend[0].due == cyc) begin
                item       = pend.pop_front();
                popped     = 1'b1;
                exp_valid  = 1'b1;
                exp_out    = item.diff;
                exp_borrow = item.brw;
                exp_cnt    = (exp_cnt + 1) % 256;
            end
            if (popped && exp_borrow) exp_uf = 1'b1;
            else if (clear_flag)      exp_uf = 1'b0;
            if (in_valid) begin
                item.due  = cyc + 1;
                item.diff = in1 - {9'd0, in2};
                item.brw  = (in1 < {9'd0, in2});
                pend.push_back(item);
            end
        end
    end

    always @(negedge clock) begin
        if (model_live) begin
            check("model out_valid", {31'd0, out_valid}, {31'd0, exp_valid});
            check("model out", {15'd0, out}, {15'd0, exp_out});
            check("model borrow", {31'd0, borrow}, {31'd0, exp_borrow});
            check("model underflow", {31'd0, underflow}, {31'd0, exp_uf});
            check("model result_count", {24'd0, result_count}, exp_cnt);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic drive(input logic v, input logic [16:0] a, input logic [7:0] b, input logic cf);
        @(negedge clock);
        in_valid   = v;
        in1        = a;
        in2        = b;
        clear_flag = cf;
    endtask

    task automatic idle();
        drive(1'b0, 17'd0, 8'd0, 1'b0);
    endtask

    // Present one pair. Return just after the falling edge at which its result is visible.
    task automatic send(input logic [16:0] a, input logic [7:0] b);
        drive(1'b1, a, b, 1'b0);
        idle();
        @(negedge clock);
        #1;
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        logic [16:0] ra;
        logic [7:0]  rb;

        tests      = 0;
        fails      = 0;
        reset      = 1'b1;
        in_valid   = 1'b0;
        in1        = '0;
        in2        = '0;
        clear_flag = 1'b0;

        repeat (2) @(negedge clock);
        reset = 1'b0;
        #1;
        check("reset out_valid", {31'd0, out_valid}, 32'd0);
        check("reset out", {15'd0, out}, 32'd0);
        check("reset underflow", {31'd0, underflow}, 32'd0);
        check("reset result_count", {24'd0, result_count}, 32'd0);

        // Basic subtraction with a borrow across the low byte
        send(17'h00105, 8'h06);
        check("basic out", {15'd0, out}, 32'h000FF);
        check("basic borrow", {31'd0, borrow}, 32'd0);
        check("basic out_valid", {31'd0, out_valid}, 32'd1);
        check("basic count", {24'd0, result_count}, 32'd1);
        @(negedge clock); #1;
        check("single pulse", {31'd0, out_valid}, 32'd0);
        check("out holds", {15'd0, out}, 32'h000FF);

        // Underflow, then the sticky flag persists until cleared
        send(17'h00005, 8'h06);
        check("uf out", {15'd0, out}, 32'h1FFFF);
        check("uf borrow", {31'd0, borrow}, 32'd1);
        check("uf flag", {31'd0, underflow}, 32'd1);
        send(17'h00105, 8'h06);
        check("uf sticky", {31'd0, underflow}, 32'd1);
        drive(1'b0, 17'd0, 8'd0, 1'b1);
        idle();
        #1;
        check("uf cleared", {31'd0, underflow}, 32'd0);

        // Boundary operands
        send(17'h1FFFF, 8'hFF);
        check("max out", {15'd0, out}, 32'h1FF00);
        check("max borrow", {31'd0, borrow}, 32'd0);
        send(17'h00100, 8'h01);
        check("cross-byte out", {15'd0, out}, 32'h000FF);

        // Three back-to-back pairs
        drive(1'b1, 17'h00010, 8'h01, 1'b0);
        drive(1'b1, 17'h00000, 8'h01, 1'b0);
        drive(1'b1, 17'h10000, 8'h80, 1'b0);
        #1;
        check("b2b1 valid", {31'd0, out_valid}, 32'd1);
        check("b2b1 out", {15'd0, out}, 32'h0000F);
        check("b2b1 borrow", {31'd0, borrow}, 32'd0);
        idle(); #1;
        check("b2b2 valid", {31'd0, out_valid}, 32'd1);
        check("b2b2 out", {15'd0, out}, 32'h1FFFF);
        check("b2b2 borrow", {31'd0, borrow}, 32'd1);
        idle(); #1;
        check("b2b3 valid", {31'd0, out_valid}, 32'd1);
        check("b2b3 out", {15'd0, out}, 32'h0FF80);
        check("b2b3 borrow", {31'd0, borrow}, 32'd0);
        idle(); #1;
        check("b2b end", {31'd0, out_valid}, 32'd0);

        // Reset while an operand sits in stage 1. A pair presented on the
        // first edge after reset deasserts is accepted.
        drive(1'b1, 17'h00105, 8'h06, 1'b0);
        @(negedge clock);
        reset    = 1'b1;
        in_valid = 1'b0;
        @(negedge clock);
        reset    = 1'b0;
        in_valid = 1'b1;
        in1      = 17'h00010;
        in2      = 8'h01;
        #1;
        check("flush out_valid", {31'd0, out_valid}, 32'd0);
        check("flush out", {15'd0, out}, 32'd0);
        check("flush count", {24'd0, result_count}, 32'd0);
        idle();
        @(negedge clock); #1;
        check("post-reset out", {15'd0, out}, 32'h0000F);
        check("post-reset count", {24'd0, result_count}, 32'd1);

        // clear_flag on the edge that writes borrow = 1: the set wins
        drive(1'b1, 17'h00000, 8'h01, 1'b0);
        drive(1'b0, 17'd0, 8'd0, 1'b1);
        @(negedge clock); #1;
        check("set wins borrow", {31'd0, borrow}, 32'd1);
        check("set wins uf", {31'd0, underflow}, 32'd1);
        idle();

        // Random traffic for the model
        for (int i = 0; i < 150; i++) begin
            ra = 17'($urandom());
            rb = 8'($urandom());
            drive(1'($urandom_range(0, 1)), ra, rb, ($urandom_range(0, 7) == 0));
        end
        idle();
        idle();

        // result_count wraps after 256 results
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        for (int i = 0; i < 256; i++) begin
            ra = 17'($urandom());
            rb = 8'($urandom());
            drive(1'b1, ra, rb, ($urandom_range(0, 15) == 0));
        end
        idle();
        idle();
        #1;
        check("wrap count", {24'd0, result_count}, 32'd0);
        send(17'h00020, 8'h10);
        check("wrap continues", {24'd0, result_count}, 32'd1);
        check("wrap out", {15'd0, out}, 32'h00010);

        idle();
        idle();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
